// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM encoding,
// the default field limit and the load clamp helper.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   // Largest legal minutes/seconds value.
   localparam int MAX_VAL = 59;

   // Limit a preset field to max_v; values above it load as max_v.
   function automatic logic [5:0] clamp_field(input logic [5:0] v, input logic [5:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command/status bundle between a controller and the countdown timer.
//
// Handshake: load, start and pause are single-cycle command pulses with an
// implicit always-ready receiver; a command is accepted on every rising edge
// where it is high (load_min/load_sec are only sampled together with load).
// minutes/seconds/running/done/alarm/state are registered status outputs,
// valid on every cycle; done is a one-cycle event flag.
interface countdown_timer_if;
   import countdown_timer_pkg::*;

   logic       load;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic       start;
   logic       pause;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       running;
   logic       done;
   logic       alarm;
   state_t     state;    // FSM state for debug/checkers

   modport master (
      output load, load_min, load_sec, start, pause,
      input  minutes, seconds, running, done, alarm, state
   );

   modport slave (
      input  load, load_min, load_sec, start, pause,
      output minutes, seconds, running, done, alarm, state
   );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ enabled cycles.
// The count holds while en is low and restarts from zero on clr.
module countdown_timer_tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);

   logic [W-1:0] cnt;

   // Count 0..CLK_HZ-1 while enabled, wrapping at the terminal count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == TERM);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: load/start/pause control FSM, seconds->minutes
// borrow, preset clamping and an expiry pulse plus latched alarm.
module countdown_timer #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int MAX_VAL = countdown_timer_pkg::MAX_VAL
) (
   input  logic               clk_100MHz,
   input  logic               reset_n,
   countdown_timer_if.slave   bus
);

   import countdown_timer_pkg::*;

   localparam logic [5:0] MAX6 = 6'(MAX_VAL);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] min_q;
   logic [5:0] sec_q;
   logic [5:0] min_d;
   logic [5:0] sec_d;
   logic       done_q;
   logic       done_d;
   logic       tick;
   logic       prescale_clr;
   logic       prescale_en;
   logic       count_zero;
   logic       last_sec;
   logic       run_tick;

   assign count_zero  = (min_q == 6'd0) && (sec_q == 6'd0);
   assign last_sec    = (min_q == 6'd0) && (sec_q == 6'd1);
   // The prescaler keeps stepping on the pause cycle itself; the held value
   // is whatever it reached on that edge.
   assign prescale_en = (state == RUN);
   // A tick only decrements when neither load nor pause outranks it.
   assign run_tick    = (state == RUN) && tick && !bus.load && !bus.pause;

   countdown_timer_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk   (clk_100MHz),
      .rst_n (reset_n),
      .en    (prescale_en),
      .clr   (prescale_clr),
      .tick  (tick)
   );

   // Next-state logic: load overrides everything, then pause, then start, then tick.
   always_comb begin
      state_nxt    = state;
      prescale_clr = 1'b0;
      done_d       = 1'b0;
      if (bus.load) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.pause && !count_zero) begin
                  state_nxt    = RUN;
                  prescale_clr = 1'b1;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_nxt = PAUSED;
               end else if (tick && last_sec) begin
                  state_nxt = EXPIRED;
                  done_d    = 1'b1;
               end
            end
            PAUSED: begin
               if (bus.start && !bus.pause) begin
                  state_nxt = RUN;
               end
            end
            EXPIRED: begin
               state_nxt = EXPIRED;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Count datapath: clamped preset on load, otherwise decrement with borrow on a tick.
   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      if (bus.load) begin
         min_d = clamp_field(bus.load_min, MAX6);
         sec_d = clamp_field(bus.load_sec, MAX6);
      end else if (run_tick) begin
         if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
         end else if (min_q != 6'd0) begin
            sec_d = MAX6;
            min_d = min_q - 6'd1;
         end
      end
   end

   // State, count and expiry pulse registers.
   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         state  <= IDLE;
         min_q  <= 6'd0;
         sec_q  <= 6'd0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         min_q  <= min_d;
         sec_q  <= sec_d;
         done_q <= done_d;
      end
   end

   assign bus.minutes = min_q;
   assign bus.seconds = sec_q;
   assign bus.running = (state == RUN);
   assign bus.done    = done_q;
   assign bus.alarm   = (state == EXPIRED);
   assign bus.state   = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random commands, a
// total-seconds reference model and an event scoreboard with cycle stamps.
module tb_countdown_timer;
   import countdown_timer_pkg::*;

   localparam int CLK_HZ = 10;
   localparam int W      = 40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   countdown_timer_if bus();

   countdown_timer #(.CLK_HZ(CLK_HZ)) dut (
      .clk_100MHz (clk),
      .reset_n    (reset_n),
      .bus        (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;

   function automatic logic [W-1:0] pack_evt(input int c, input logic [5:0] mi, input logic [5:0] se,
                                             input logic r, input logic d, input logic a,
                                             input logic [1:0] st);
      logic [15:0] c16;
      c16 = c[15:0];
      return {7'd0, c16, mi, se, r, d, a, st};
   endfunction

   function automatic string fmt_evt(input logic [W-1:0] e);
      return $sformatf("cyc=%0d %0d:%0d run=%0b done=%0b alarm=%0b state=%0d",
                       e[32:17], e[16:11], e[10:5], e[4], e[3], e[2], e[1:0]);
   endfunction

   // ---------------- reference model ----------------
   // Time left is kept as total seconds; minutes/seconds come from /60 and %60.
   int     m_remain = 0;
   int     m_phase  = 0;    // enabled cycles since the current second began
   state_t m_state  = IDLE;
   logic   m_done   = 1'b0;
   logic [16:0] m_prev = '0;
   logic   m_prev_v = 1'b0;

   task automatic model_step(input logic rst, input logic ld, input logic [5:0] lm,
                             input logic [5:0] ls, input logic st, input logic pa);
      int lmin;
      int lsec;
      bit tick_now;
      logic [5:0] mi;
      logic [5:0] se;
      logic [16:0] obs;
      m_done = 1'b0;
      if (!rst) begin
         m_remain = 0;
         m_phase  = 0;
         m_state  = IDLE;
      end else if (ld) begin
         lmin = (int'(lm) > MAX_VAL) ? MAX_VAL : int'(lm);
         lsec = (int'(ls) > MAX_VAL) ? MAX_VAL : int'(ls);
         m_remain = lmin * 60 + lsec;
         m_state  = IDLE;
      end else begin
         case (m_state)
            IDLE: if (st && !pa && m_remain > 0) begin
               m_state = RUN;
               m_phase = 0;
            end
            RUN: begin
               tick_now = (m_phase == CLK_HZ - 1);
               m_phase  = (m_phase + 1) % CLK_HZ;
               if (pa) begin
                  m_state = PAUSED;
               end else if (tick_now) begin
                  m_remain = m_remain - 1;
                  if (m_remain == 0) begin
                     m_state = EXPIRED;
                     m_done  = 1'b1;
                  end
               end
            end
            PAUSED: if (st && !pa) m_state = RUN;
            default: ;
         endcase
      end
      mi  = 6'(m_remain / 60);
      se  = 6'(m_remain % 60);
      obs = {mi, se, (m_state == RUN), m_done, (m_state == EXPIRED), 2'(m_state)};
      if (!m_prev_v || obs != m_prev) begin
         exp_q.push_back(pack_evt(cyc + 1, mi, se, obs[4], obs[3], obs[2], obs[1:0]));
      end
      m_prev   = obs;
      m_prev_v = 1'b1;
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic ld, input logic [5:0] lm,
                        input logic [5:0] ls, input logic st, input logic pa);
      @(negedge clk);
      reset_n      = rst;
      bus.load     = ld;
      bus.load_min = lm;
      bus.load_sec = ls;
      bus.start    = st;
      bus.pause    = pa;
      model_step(rst, ld, lm, ls, st, pa);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [5:0] lm, input logic [5:0] ls);
      drive(1'b1, 1'b1, lm, ls, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
   endtask

   task automatic do_pause();
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   // Any change of the visible outputs is an event; it must match the next
   // expected event in value and in the cycle on which it appeared.
   initial begin : monitor
      logic [16:0] prev;
      logic [16:0] obs;
      logic        prev_v;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      prev_v = 1'b0;
      prev   = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            obs = {bus.minutes, bus.seconds, bus.running, bus.done, bus.alarm, 2'(bus.state)};
            if (!prev_v || obs != prev) begin
               got = pack_evt(cyc, obs[16:11], obs[10:5], obs[4], obs[3], obs[2], obs[1:0]);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_event: got %s, required no event", fmt_evt(got));
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     failures++;
                     $display("FAIL event: got %s, required %s", fmt_evt(got), fmt_evt(exp));
                  end
               end
            end
            prev   = obs;
            prev_v = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n      = 1'b0;
      bus.load     = 1'b0;
      bus.load_min = 6'd0;
      bus.load_sec = 6'd0;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;

      do_reset(1);
      mon_en = 1'b1;
      do_reset(1);

      // 00:03 to expiry, then start/pause must not disturb EXPIRED
      do_load(6'd0, 6'd3);
      do_start();
      idle(33);
      do_start();
      do_pause();
      idle(2);
      // reload leaves EXPIRED
      do_load(6'd0, 6'd2);
      idle(2);

      // reset in the middle of a run
      do_start();
      idle(6);
      do_reset(2);
      idle(2);

      // borrow and clamp
      do_load(6'd1, 6'd0);
      do_start();
      idle(12);
      do_load(6'd63, 6'd70);
      idle(2);

      // pause/resume keeps the prescaler phase
      do_load(6'd0, 6'd5);
      do_start();
      idle(14);
      do_pause();
      idle(50);
      do_start();
      idle(12);

      // start+pause together: RUN -> PAUSED, IDLE stays IDLE
      do_load(6'd0, 6'd9);
      do_start();
      idle(5);
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
      idle(3);
      do_load(6'd0, 6'd4);
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
      idle(3);

      // start with 00:00 is ignored
      do_load(6'd0, 6'd0);
      do_start();
      idle(3);

      // random command mix
      for (int i = 0; i < 600; i++) begin
         logic       rst;
         logic       ld;
         logic       st;
         logic       pa;
         logic [5:0] lm;
         logic [5:0] ls;
         rst = ($urandom_range(0, 199) != 0);
         ld  = ($urandom_range(0, 39) == 0);
         st  = ($urandom_range(0, 7) == 0);
         pa  = ($urandom_range(0, 24) == 0);
         lm  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         ls  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
         drive(rst, ld, lm, ls, st, pa);
      end
      idle(3);

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: got %0d pending events, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
